// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared definitions for the alarm path: ring-controller state encoding,
// BCD HH:MM field layout, LED patterns and the BCD time validity check.
// The alarm-set service uses the same validity check.
// No ports (package).
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } alarm_state_t;

  // Layout of a 16-bit BCD time word {H10,H1,M10,M1}
  localparam int BCD_W   = 4;
  localparam int H10_LSB = 12;
  localparam int H1_LSB  = 8;
  localparam int M10_LSB = 4;
  localparam int M1_LSB  = 0;

  localparam logic [15:0] LED_ON  = 16'hFFFF;
  localparam logic [15:0] LED_OFF = 16'h0000;

  // True when the word is a legal 24-hour time 00:00..23:59.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    h10 = t[H10_LSB +: BCD_W];
    h1  = t[H1_LSB  +: BCD_W];
    m10 = t[M10_LSB +: BCD_W];
    m1  = t[M1_LSB  +: BCD_W];
    // With H10 already limited to 2, HH<=23 only fails for 24..29
    return (h10 <= 4'd2) && (h1 <= 4'd9) && (m10 <= 4'd5) && (m1 <= 4'd9) &&
           !((h10 == 4'd2) && (h1 > 4'd3));
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge
// Rising-edge detector for one push-button level. The pulse is registered,
// so it appears on the cycle after the level was first sampled high;
// a held button gives exactly one pulse.
// Ports:
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   btn    in  button level
//   pulse  out one-cycle pulse per 0->1 transition of btn
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic pulse
);

  logic btn_q;

  // Previous level plus registered edge pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl
// Latches the BCD HH:MM alarm published by the alarm-set service, compares it
// with the running time and drives the ring indication until dismissed,
// timed out or (optionally) snoozed.
// Optional feature macro: ALARM_SNOOZE_EN (builds the SNOOZE state, snooze
// counter and push_u handling; without it push_u is ignored).
// Parameters:
//   RING_SECS   seconds a ring lasts before auto-stop (1..255)
//   SNOOZE_SECS seconds of snooze before re-ring (1..1023)
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   alarm_valid   one-cycle load strobe for alarm
//   alarm         BCD {H10,H1,M10,M1} alarm time
//   cur_time      BCD {H10,H1,M10,M1} current time
//   sec_tick      one-cycle pulse per second
//   push_c/u/d    dismiss / snooze / disarm button levels
//   armed         alarm loaded and active
//   ringing       ring in progress
//   led           blink pattern (FFFF on even seconds of a ring)
//   ring_done     one-cycle pulse when a ring ends by dismiss or timeout
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        alarm_valid,
  input  logic [15:0] alarm,
  input  logic [15:0] cur_time,
  input  logic        sec_tick,
  input  logic        push_c,
  input  logic        push_u,
  input  logic        push_d,
  output logic        armed,
  output logic        ringing,
  output logic [15:0] led,
  output logic        ring_done
);

  // Terminal count is checked against the value before the increment, so
  // the ring ends on the same edge that would make the count RING_SECS.
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
`endif

  alarm_state_t state;
  alarm_state_t state_nx;
  logic [15:0]  alarm_reg;
  logic         match;
  logic         match_d;
  logic         load_ok;
  logic [7:0]   ring_cnt;
  logic [7:0]   ring_cnt_nx;
  logic         phase;
  logic         phase_nx;
  logic         done_nx;
  logic         ev_c;
  logic         ev_u;
  logic         ev_d;
`ifdef ALARM_SNOOZE_EN
  logic [9:0]   snz_cnt;
  logic [9:0]   snz_cnt_nx;
`endif

  btn_edge u_edge_c (.clk(clk), .resetn(resetn), .btn(push_c), .pulse(ev_c));
  btn_edge u_edge_u (.clk(clk), .resetn(resetn), .btn(push_u), .pulse(ev_u));
  btn_edge u_edge_d (.clk(clk), .resetn(resetn), .btn(push_d), .pulse(ev_d));

  assign load_ok = alarm_valid && bcd_time_valid(alarm);
  assign match   = (cur_time == alarm_reg);

  // Next state. A valid load overrides everything; within RING the order is
  // dismiss, timeout, snooze, then plain second counting. In ARMED, disarm
  // wins over a coincident match edge.
  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    phase_nx    = phase;
    done_nx     = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nx  = snz_cnt;
`endif
    if (load_ok) begin
      state_nx    = ARMED;
      ring_cnt_nx = 8'd0;
      phase_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        ARMED: begin
          if (ev_d) begin
            state_nx = IDLE;
          end else if (match && !match_d) begin
            state_nx    = RING;
            ring_cnt_nx = 8'd0;
            phase_nx    = 1'b0;
          end
        end
        RING: begin
          if (ev_c) begin
            state_nx = ARMED;
            done_nx  = 1'b1;
          end else if (sec_tick && (ring_cnt == RING_LAST)) begin
            state_nx = ARMED;
            done_nx  = 1'b1;
`ifdef ALARM_SNOOZE_EN
          end else if (ev_u) begin
            state_nx   = SNOOZE;
            snz_cnt_nx = 10'd0;
`endif
          end else if (sec_tick) begin
            ring_cnt_nx = ring_cnt + 8'd1;
            phase_nx    = ~phase;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (ev_c) begin
            state_nx = ARMED;
            done_nx  = 1'b1;
          end else if (sec_tick && (snz_cnt == SNOOZE_LAST)) begin
            state_nx    = RING;
            ring_cnt_nx = 8'd0;
            phase_nx    = 1'b0;
          end else if (sec_tick) begin
            snz_cnt_nx = snz_cnt + 10'd1;
          end
        end
`endif
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State, counters, alarm latch and match history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ring_cnt  <= 8'd0;
      phase     <= 1'b0;
      alarm_reg <= 16'h0000;
      match_d   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt   <= 10'd0;
`endif
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
      phase    <= phase_nx;
      match_d  <= match;
      if (load_ok) begin
        alarm_reg <= alarm;
      end
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_cnt_nx;
`endif
    end
  end

  // Outputs are decoded from the next-state values so they change on the
  // same edge as the state itself, glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed     <= 1'b0;
      ringing   <= 1'b0;
      led       <= LED_OFF;
      ring_done <= 1'b0;
    end else begin
      armed     <= (state_nx != IDLE);
      ringing   <= (state_nx == RING);
      led       <= ((state_nx == RING) && !phase_nx) ? LED_ON : LED_OFF;
      ring_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl
// Drives alarm_ring_ctrl with directed scenarios followed by randomized
// traffic, and compares every cycle against a behavioural model of the
// alarm rules kept in this file. Honours ALARM_SNOOZE_EN like the design.
module tb_alarm_ring_ctrl;

  localparam int RS = 3;
  localparam int SS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  localparam int M_IDLE   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_RING   = 2;
  localparam int M_SNOOZE = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        alarm_valid = 1'b0;
  logic [15:0] alarm = 16'h0000;
  logic [15:0] cur_time = 16'h0000;
  logic        sec_tick = 1'b0;
  logic        push_c = 1'b0;
  logic        push_u = 1'b0;
  logic        push_d = 1'b0;
  logic        armed;
  logic        ringing;
  logic [15:0] led;
  logic        ring_done;

  int checks = 0;
  int errors = 0;

  alarm_ring_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
    .clk(clk), .resetn(resetn), .alarm_valid(alarm_valid), .alarm(alarm),
    .cur_time(cur_time), .sec_tick(sec_tick), .push_c(push_c), .push_u(push_u),
    .push_d(push_d), .armed(armed), .ringing(ringing), .led(led),
    .ring_done(ring_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_mode = M_IDLE;
  logic [15:0] m_alarm = 16'h0000;
  bit          m_prev_match = 1'b0;
  int          m_ring_secs = 0;
  int          m_snz_secs = 0;
  bit          m_done = 1'b0;
  bit          hc0 = 0, hc1 = 0, hu0 = 0, hu1 = 0, hd0 = 0, hd1 = 0;
  bit          ev_c, ev_u, ev_d, now_match, rise;

  function automatic bit bcd_ok(input logic [15:0] t);
    int h10, h1, m10, m1;
    h10 = int'(t[15:12]);
    h1  = int'(t[11:8]);
    m10 = int'(t[7:4]);
    m1  = int'(t[3:0]);
    return (h10 <= 9) && (h1 <= 9) && (m10 <= 9) && (m1 <= 9) &&
           (h10 * 10 + h1 <= 23) && (m10 * 10 + m1 <= 59);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_IDLE; m_alarm = 16'h0000; m_prev_match = 1'b0;
      m_ring_secs = 0; m_snz_secs = 0; m_done = 1'b0;
      hc0 = 0; hc1 = 0; hu0 = 0; hu1 = 0; hd0 = 0; hd1 = 0;
    end else begin
      // a press acts one cycle after its level was first sampled high
      ev_c = hc0 && !hc1; ev_u = hu0 && !hu1; ev_d = hd0 && !hd1;
      hc1 = hc0; hc0 = push_c; hu1 = hu0; hu0 = push_u; hd1 = hd0; hd0 = push_d;
      now_match = (cur_time == m_alarm);
      rise = now_match && !m_prev_match;
      m_prev_match = now_match;
      m_done = 1'b0;
      if (alarm_valid && bcd_ok(alarm)) begin
        m_alarm = alarm;
        m_mode  = M_ARMED;
      end else if (m_mode == M_ARMED) begin
        if (ev_d) m_mode = M_IDLE;
        else if (rise) begin m_mode = M_RING; m_ring_secs = 0; end
      end else if (m_mode == M_RING) begin
        if (ev_c) begin m_mode = M_ARMED; m_done = 1'b1; end
        else if (sec_tick && (m_ring_secs + 1 == RS)) begin m_mode = M_ARMED; m_done = 1'b1; end
        else if (SNOOZE_ON && ev_u) begin m_mode = M_SNOOZE; m_snz_secs = 0; end
        else if (sec_tick) m_ring_secs = m_ring_secs + 1;
      end else if (m_mode == M_SNOOZE) begin
        if (ev_c) begin m_mode = M_ARMED; m_done = 1'b1; end
        else if (sec_tick) begin
          m_snz_secs = m_snz_secs + 1;
          if (m_snz_secs == SS) begin m_mode = M_RING; m_ring_secs = 0; end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checkOutput("armed", 16'(armed), 16'(m_mode != M_IDLE));
    checkOutput("ringing", 16'(ringing), 16'(m_mode == M_RING));
    checkOutput("led", led, ((m_mode == M_RING) && (m_ring_secs % 2 == 0)) ? 16'hFFFF : 16'h0000);
    checkOutput("ring_done", 16'(ring_done), 16'(m_done));
  end

  // Drive one cycle of inputs at the falling edge, return just after the rise
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic tick,
                               input logic c, input logic u, input logic d);
    @(negedge clk);
    alarm_valid = v; alarm = a; sec_tick = tick;
    push_c = c; push_u = u; push_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] times [5] = '{16'h0937, 16'h0938, 16'h0939, 16'h2359, 16'h0000};
  logic [15:0] alarms [7] = '{16'h0937, 16'h0938, 16'h0939, 16'h2359, 16'h0000, 16'h2460, 16'h1975};
  logic lc, lu, ld;

  initial begin
    $display("[TB] start, RING_SECS=%0d SNOOZE_SECS=%0d snooze=%0d", RS, SS, SNOOZE_ON);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_armed", 16'(armed), 16'd0);
    checkOutput("rst_ringing", 16'(ringing), 16'd0);
    checkOutput("rst_led", led, 16'h0000);
    checkOutput("rst_done", 16'(ring_done), 16'd0);
    resetn = 1'b1;

    // load 09:38 and ring on the minute change
    cur_time = 16'h0937;
    applyStimulus(1'b1, 16'h0938, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load_armed", 16'(armed), 16'd1);
    idle();
    checkOutput("pre_ring", 16'(ringing), 16'd0);
    cur_time = 16'h0938;
    idle();
    checkOutput("ring_rise", 16'(ringing), 16'd1);
    checkOutput("led_on", led, 16'hFFFF);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("led_off", led, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("led_on2", led, 16'hFFFF);

    // dismiss: effect two cycles after the press
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dismiss_wait", 16'(ringing), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dismiss_ring", 16'(ringing), 16'd0);
    checkOutput("dismiss_done", 16'(ring_done), 16'd1);
    idle();
    checkOutput("done_pulse", 16'(ring_done), 16'd0);
    repeat (3) idle();
    checkOutput("no_rering", 16'(ringing), 16'd0);

    // timeout after RS ticks
    cur_time = 16'h0939; idle();
    cur_time = 16'h0938; idle();
    checkOutput("ring2_rise", 16'(ringing), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("tick2_ring", 16'(ringing), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout_ring", 16'(ringing), 16'd0);
    checkOutput("timeout_done", 16'(ring_done), 16'd1);

    // snooze (or push_u ignored)
    cur_time = 16'h0939; idle();
    cur_time = 16'h0938; idle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALARM_SNOOZE_EN
    checkOutput("snooze_quiet", 16'(ringing), 16'd0);
    checkOutput("snooze_armed", 16'(armed), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("snooze_tick1", 16'(ringing), 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("snooze_rering", 16'(ringing), 16'd1);
    checkOutput("snooze_led", led, 16'hFFFF);
`else
    checkOutput("push_u_ignored", 16'(ringing), 16'd1);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dismiss2_done", 16'(ring_done), 16'd1);
    idle();

    // invalid load ignored, alarm still 09:38
    applyStimulus(1'b1, 16'h2460, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("inval_armed", 16'(armed), 16'd1);
    cur_time = 16'h2460; idle();
    checkOutput("inval_noring", 16'(ringing), 16'd0);
    cur_time = 16'h0938; idle();
    checkOutput("kept_alarm", 16'(ringing), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    // disarm
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("disarm", 16'(armed), 16'd0);
    idle();
    cur_time = 16'h0939; idle();
    cur_time = 16'h0938; idle();
    checkOutput("disarm_noring", 16'(ringing), 16'd0);

    // reset mid-ring
    cur_time = 16'h0937;
    applyStimulus(1'b1, 16'h0938, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_time = 16'h0938; idle();
    checkOutput("ring3_rise", 16'(ringing), 16'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_ringing", 16'(ringing), 16'd0);
    checkOutput("arst_armed", 16'(armed), 16'd0);
    checkOutput("arst_led", led, 16'h0000);
    @(posedge clk); #3 resetn = 1'b1;
    cur_time = 16'h0937; idle();
    cur_time = 16'h0938; idle();
    checkOutput("post_rst_noring", 16'(ringing), 16'd0);

    // randomized traffic against the model
    lc = 1'b0; lu = 1'b0; ld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) cur_time = times[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) lc = ~lc;
      if ($urandom_range(0, 5) == 0) lu = ~lu;
      if ($urandom_range(0, 11) == 0) ld = ~ld;
      v = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : alarms[$urandom_range(0, 6)];
      applyStimulus(v, a, 1'($urandom_range(0, 3) == 0), lc, lu, ld);
      if ($urandom_range(0, 599) == 0) begin
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
      end
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
